// File: rtl/alu_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Contents: op-code enum, data/op widths, request payload struct,
// and the op-code legality helper.
package alu_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned N_REQ   = 2;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned SHAMT_W = 5;

  // Highest legal op code; codes above it return zero with an error flag.
  localparam logic [OP_W-1:0] ALU_OP_MAX = 4'd9;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLT  = 4'd5,
    OP_SLTU = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9
  } alu_op_e;

  // One ALU operation as presented by a requester. sel is kept raw so that
  // the illegal codes 10-15 can travel through unchanged.
  typedef struct packed {
    logic [OP_W-1:0]   sel;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } alu_req_t;

  function automatic logic op_is_valid(input logic [OP_W-1:0] sel);
    return (sel <= ALU_OP_MAX);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters and the ALU arbiter.
// Request side : req_valid/req_ready handshake with per-requester a, b, sel.
// Response side: per-requester rsp_valid/rsp_ready with shared rsp_data/rsp_err.
// master = requester side, slave = arbiter side.
interface alu_arbiter_if;
  import alu_pkg::*;

  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ-1:0]             req_ready;
  logic [N_REQ-1:0][DATA_W-1:0] req_a;
  logic [N_REQ-1:0][DATA_W-1:0] req_b;
  logic [N_REQ-1:0][OP_W-1:0]   req_sel;
  logic [N_REQ-1:0]             rsp_valid;
  logic [N_REQ-1:0]             rsp_ready;
  logic [DATA_W-1:0]            rsp_data;
  logic                         rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Plain combinational ALU shared by the arbiter.
// Ports: op_i       - operation payload (sel, a, b)
//        result_c_o - combinational result; unknown op codes yield 0
module alu_arbiter_alu
  import alu_pkg::*;
(
  input  alu_req_t          op_i,
  output logic [DATA_W-1:0] result_c_o
);

  logic [SHAMT_W-1:0] shamt;

  assign shamt = op_i.b[SHAMT_W-1:0];

  // Op decode; shifts use only the low five bits of b.
  always_comb begin
    result_c_o = '0;
    case (alu_op_e'(op_i.sel))
      OP_ADD:  result_c_o = op_i.a + op_i.b;
      OP_SUB:  result_c_o = op_i.a - op_i.b;
      OP_AND:  result_c_o = op_i.a & op_i.b;
      OP_OR:   result_c_o = op_i.a | op_i.b;
      OP_XOR:  result_c_o = op_i.a ^ op_i.b;
      OP_SLT:  result_c_o = {{(DATA_W-1){1'b0}}, ($signed(op_i.a) < $signed(op_i.b))};
      OP_SLTU: result_c_o = {{(DATA_W-1){1'b0}}, (op_i.a < op_i.b)};
      OP_SLL:  result_c_o = op_i.a << shamt;
      OP_SRL:  result_c_o = op_i.a >> shamt;
      OP_SRA:  result_c_o = DATA_W'($signed(op_i.a) >>> shamt);
      default: result_c_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, one op in flight.
// Ports: clk, rst_n (async active-low)
//        bus - slave side of alu_arbiter_if:
//              req_valid/req_ready/req_a/req_b/req_sel in,
//              rsp_valid/rsp_ready/rsp_data/rsp_err out.
// req_ready is combinational from req_valid, state and priority pointer;
// response outputs come straight from registers.
module alu_arbiter #(
  parameter int unsigned DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);
  import alu_pkg::*;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              ptr_q,   ptr_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              err_q,   err_d;

  logic              accept_c;
  logic              gnt_any_c;
  logic              gnt_id_c;
  logic [N_REQ-1:0]  gnt_c;
  alu_req_t          alu_in_c;
  logic [DATA_W-1:0] alu_res_c;
  logic              op_ok_c;

  // A new op may enter when idle, or when the current owner drains this cycle.
  assign accept_c = (state_q == ST_IDLE) ||
                    ((state_q == ST_HOLD) && bus.rsp_ready[owner_q]);

  // Grant select: a lone requester wins, a tie goes to the pointer.
  // rst_n gates the grant so nothing handshakes while reset is held.
  always_comb begin
    gnt_any_c = 1'b0;
    gnt_id_c  = 1'b0;
    if (rst_n && accept_c) begin
      case (bus.req_valid)
        2'b01: begin gnt_any_c = 1'b1; gnt_id_c = 1'b0;  end
        2'b10: begin gnt_any_c = 1'b1; gnt_id_c = 1'b1;  end
        2'b11: begin gnt_any_c = 1'b1; gnt_id_c = ptr_q; end
        default: begin gnt_any_c = 1'b0; gnt_id_c = 1'b0; end
      endcase
    end
  end

  assign gnt_c = gnt_any_c ? (N_REQ'(1) << gnt_id_c) : '0;

  // Operand mux into the single ALU instance.
  always_comb begin
    alu_in_c.sel = bus.req_sel[gnt_id_c];
    alu_in_c.a   = bus.req_a[gnt_id_c];
    alu_in_c.b   = bus.req_b[gnt_id_c];
  end

  alu_arbiter_alu u_alu (
    .op_i       (alu_in_c),
    .result_c_o (alu_res_c)
  );

  assign op_ok_c = op_is_valid(alu_in_c.sel);

  // State and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      ptr_q       <= 1'b0;
      rsp_valid_q <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      data_q      <= data_d;
      err_q       <= err_d;
    end
  end

  // Next state: load a new result on grant, drop to IDLE when drained with no
  // replacement, otherwise hold the response untouched.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    data_d      = data_q;
    err_d       = err_q;

    case (state_q)
      ST_IDLE: begin
        rsp_valid_d = '0;
      end
      ST_HOLD: begin
        if (bus.rsp_ready[owner_q]) begin
          state_d     = ST_IDLE;
          rsp_valid_d = '0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = '0;
      end
    endcase

    if (gnt_any_c) begin
      state_d     = ST_HOLD;
      owner_d     = gnt_id_c;
      ptr_d       = ~gnt_id_c;
      rsp_valid_d = N_REQ'(1) << gnt_id_c;
      data_d      = op_ok_c ? alu_res_c : '0;
      err_d       = ~op_ok_c;
    end
  end

  assign bus.req_ready = gnt_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width; other values unsupported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  input  2  per-requester request valid; bit 0 = requester 0, bit 1 = requester 1.
REQ-005 req_ready  output  2  per-requester request accepted this cycle; one-hot or zero.
REQ-006 req_a  input  2xDATA_W  per-requester operand A.
REQ-007 req_b  input  2xDATA_W  per-requester operand B.
REQ-008 req_sel  input  2x4  per-requester ALU op code.
REQ-009 rsp_valid  output  2  per-requester response valid; one-hot or zero.
REQ-010 rsp_ready  input  2  per-requester response consumed.
REQ-011 rsp_data  output  DATA_W  result shared by both requesters; meaningful only where rsp_valid is set.
REQ-012 rsp_err  output  1  op code invalid for the current response; meaningful only with rsp_valid.

Function
REQ-013 Shares one ALU instance between two requesters; at most one operation in flight.
REQ-014 States: IDLE (no response pending) and HOLD (response registered, awaiting rsp_ready of owner).
REQ-015 Accept condition: state IDLE, or state HOLD with the owner's rsp_ready=1 in the same cycle (back-to-back, no bubble).
REQ-016 Grant: when the accept condition holds and any req_valid is set, exactly one req_ready is set (the grantee); grant is combinational from req_valid, state, and priority pointer.
REQ-017 Single valid request is granted regardless of pointer.
REQ-018 Both valid: grant the requester indicated by the priority pointer.
REQ-019 After each grant, the pointer moves to the non-granted requester (round-robin).
REQ-020 Pointer reset value: 0.
REQ-021 Handshake: transfer occurs when req_valid[i] & req_ready[i].
REQ-022 Requesters hold a, b, sel stable while valid and not ready; the arbiter does not register request-side state before the grant.
REQ-023 Latency: ALU result and owner ID register on the accept edge; rsp_valid[owner]=1 from the next cycle (1-cycle latency).
REQ-024 rsp_data, rsp_err, and rsp_valid remain stable in HOLD until the owner's rsp_ready=1.
REQ-025 Response consumed with no new grant -> IDLE, rsp_valid=0.
REQ-026 Response consumed with a new grant in the same cycle -> remain HOLD with the new result and owner.
REQ-027 Valid op codes (alu_op_e): 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA.
REQ-028 Shift ops use b[4:0] only; ADD/SUB wrap modulo 2^32, no overflow flag.
REQ-029 Op codes 10-15 are accepted normally and produce rsp_data=0, rsp_err=1.
REQ-030 rsp_ready on a bit with rsp_valid=0 is ignored.
REQ-031 req_ready is never asserted for a requester whose req_valid=0.

Reset
REQ-032 rst_n=0 forces immediately: state IDLE, rsp_valid=0, rsp_data=0, rsp_err=0, owner=0, pointer=0.
REQ-033 During reset, req_ready=0.
REQ-034 A response pending in HOLD when reset asserts is discarded; it is not replayed after reset.
REQ-035 First grant is possible in the first cycle after rst_n deasserts.

Structure
REQ-036 Shared package alu_pkg holds: alu_op_e enum (4-bit, values per REQ-027), DATA_W constant, ALU_OP_MAX=9.
REQ-037 Sub-module: existing ALU, instantiated once, operands muxed by grant.
REQ-038 Invalid-op detection and result zeroing live in alu_arbiter, not in the ALU.

Verification
REQ-039 Req0 only: a=1, b=2, sel=0 -> req_ready=01 same cycle; next cycle rsp_valid=01, rsp_data=3, rsp_err=0.
REQ-040 Both valid from reset: req0 sel=1 a=0x80000000 b=1, req1 sel=9 a=0xF0000000 b=4.
  -> Req0 granted first, rsp_data=0x7FFFFFFF.
  -> Req1 granted next, rsp_data=0xFF000000.
  -> Pointer alternates thereafter.
REQ-041 Backpressure: hold rsp_ready=0 for 5 cycles.
  -> rsp_data stable throughout; req_ready=00.
  -> On rsp_ready=1 with a pending request, next grant in the same cycle; no bubble.
REQ-042 Invalid op: sel=12 -> rsp_err=1, rsp_data=0; next op sel=5 a=0xFFFFFFFF b=1 -> rsp_data=1, rsp_err=0.
REQ-043 Reset in HOLD: assert rst_n=0 mid-cycle.
  -> rsp_valid drops immediately, all outputs 0.
  -> After release, first request from req1 is granted with no stale response.
